// File: rtl/mar_seq.sv
// mar_seq: SAP-1 memory address register with synchronised run/manual mode.
// Holds a load/increment address and muxes it or the switches onto RAM address lines.
module mar_seq #(
  parameter int              ADDR_W      = 4,
  parameter int              SYNC_STAGES = 2,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  parameter bit              SEED_ON_RUN = 1'b1
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [ADDR_W-1:0] d,
  input  logic [ADDR_W-1:0] a,
  input  logic              n_lm,
  input  logic              inc,
  input  logic              ch_s2,
  output logic [ADDR_W-1:0] s,
  output logic              mode_run,
  output logic              wrap
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [ADDR_W-1:0]      r_q;
  logic                   r_wrap;
  logic                   w_seed;
  logic                   w_inc_go;

  assign mode_run = r_sync[SYNC_STAGES-1];
  assign w_seed   = SEED_ON_RUN
                  & r_sync[SYNC_STAGES-2]
                  & ~r_sync[SYNC_STAGES-1];
  assign w_inc_go = ~w_seed & n_lm & inc;
  assign s        = mode_run ? r_q : a;
  assign wrap     = r_wrap;

  // Mode switch synchroniser; only the first stage touches ch_s2.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], ch_s2};
    end
  end

  // Address register: seed beats load beats increment.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_q <= RESET_ADDR;
    end else if (w_seed) begin
      r_q <= a;
    end else if (!n_lm) begin
      r_q <= d;
    end else if (inc) begin
      r_q <= r_q + 1'b1;
    end
  end

  // One-cycle rollover flag, only when the increment was really taken.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= w_inc_go & (&r_q);
    end
  end

endmodule

// File: tb/tb_mar_seq.sv
// tb_mar_seq: directed bench for mar_seq in two configurations.
// A per-edge behavioural model is compared against both DUTs every cycle.
module tb_mar_seq;

  logic       clk;
  logic       n_rst;
  logic [7:0] d;
  logic [7:0] a;
  logic       n_lm;
  logic       inc;
  logic       ch_s2;

  logic [3:0] s0;
  logic       mode0;
  logic       wrap0;
  logic [7:0] s1;
  logic       mode1;
  logic       wrap1;

  int errors = 0;
  int checks = 0;

  mar_seq u_dut0 (
    .clk(clk), .n_rst(n_rst), .d(d[3:0]), .a(a[3:0]),
    .n_lm(n_lm), .inc(inc), .ch_s2(ch_s2),
    .s(s0), .mode_run(mode0), .wrap(wrap0)
  );

  mar_seq #(
    .ADDR_W(8), .SYNC_STAGES(3),
    .RESET_ADDR(8'h10), .SEED_ON_RUN(1'b0)
  ) u_dut1 (
    .clk(clk), .n_rst(n_rst), .d(d), .a(a),
    .n_lm(n_lm), .inc(inc), .ch_s2(ch_s2),
    .s(s1), .mode_run(mode1), .wrap(wrap1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Configuration table for the model
  int W  [2] = '{4, 8};
  int S  [2] = '{2, 3};
  int R  [2] = '{0, 16};
  int SD [2] = '{1, 0};

  // Model state: address, effective mode, wrap flag,
  // and the recent ch_s2 samples (bit k = sample k+1 edges back).
  int        mq   [2];
  bit        mmode[2];
  bit        mwrap[2];
  bit [7:0]  hist [2];

  function automatic int mask(int i);
    return (1 << W[i]) - 1;
  endfunction

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < 2; i++) begin
        mq[i]    <= R[i];
        mmode[i] <= 1'b0;
        mwrap[i] <= 1'b0;
        hist[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        bit [7:0] h;
        bit       nm;
        int       q;
        bit       w;
        h  = {hist[i][6:0], ch_s2};
        nm = h[S[i]-1];
        q  = mq[i];
        w  = 1'b0;
        if (SD[i] != 0 && nm && !mmode[i]) q = a & mask(i);
        else if (!n_lm) q = d & mask(i);
        else if (inc) begin
          w = (q == mask(i));
          q = (q + 1) & mask(i);
        end
        hist[i]  <= h;
        mmode[i] <= nm;
        mq[i]    <= q;
        mwrap[i] <= w;
      end
    end
  end

  function automatic int exp_s(int i);
    return mmode[i] ? mq[i] : (a & mask(i));
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model
  always @(posedge clk) begin
    #1;
    chk("s0_model", {28'd0, s0}, exp_s(0));
    chk("mode0_model", mode0, mmode[0]);
    chk("wrap0_model", wrap0, mwrap[0]);
    chk("s1_model", {24'd0, s1}, exp_s(1));
    chk("mode1_model", mode1, mmode[1]);
    chk("wrap1_model", wrap1, mwrap[1]);
  end

  task automatic nedge(int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_rst = 1'b0; ch_s2 = 1'b0; a = 8'h0A;
    d = 8'h00; n_lm = 1'b1; inc = 1'b0;
    #3;
    chk("rst_s0", s0, 4'hA);
    chk("rst_mode0", mode0, 1'b0);
    chk("rst_s1", s1, 8'h0A);
    nedge(2);
    n_rst = 1'b1;

    // Manual load: register changes but is hidden
    n_lm = 1'b0; d = 8'h03;
    nedge(1);
    n_lm = 1'b1;
    chk("man_s0", s0, 4'hA);
    chk("man_mode0", mode0, 1'b0);

    // Enter run, seeded from switches on DUT0
    a = 8'h05; ch_s2 = 1'b1;
    nedge(1);
    chk("sync_e1_mode0", mode0, 1'b0);
    nedge(1);
    chk("sync_e2_mode0", mode0, 1'b1);
    chk("seed_s0", s0, 4'h5);
    chk("sync_e2_mode1", mode1, 1'b0);
    nedge(1);
    chk("sync_e3_mode1", mode1, 1'b1);
    chk("noseed_s1", s1, 8'h03);
    n_lm = 1'b0; d = 8'h09;
    nedge(1);
    n_lm = 1'b1;
    chk("load9_s0", s0, 4'h9);
    chk("load9_s1", s1, 8'h09);

    // Increment through rollover
    n_lm = 1'b0; d = 8'h0E;
    nedge(1);
    n_lm = 1'b1; inc = 1'b1;
    chk("loadE_s0", s0, 4'hE);
    nedge(1);
    chk("incF_s0", s0, 4'hF);
    chk("incF_wrap0", wrap0, 1'b0);
    nedge(1);
    chk("inc0_s0", s0, 4'h0);
    chk("inc0_wrap0", wrap0, 1'b1);
    nedge(1);
    inc = 1'b0;
    chk("inc1_s0", s0, 4'h1);
    chk("inc1_wrap0", wrap0, 1'b0);
    chk("inc_s1", s1, 8'h11);

    // Load beats increment, even at all ones
    n_lm = 1'b0; d = 8'h0F;
    nedge(1);
    chk("loadF_s0", s0, 4'hF);
    d = 8'h02; inc = 1'b1;
    nedge(1);
    n_lm = 1'b1; inc = 1'b0;
    chk("ldinc_s0", s0, 4'h2);
    chk("ldinc_wrap0", wrap0, 1'b0);
    chk("ldinc_s1", s1, 8'h02);

    // Seed beats load
    ch_s2 = 1'b0;
    nedge(4);
    chk("man2_mode0", mode0, 1'b0);
    chk("man2_mode1", mode1, 1'b0);
    a = 8'h07; ch_s2 = 1'b1; n_lm = 1'b0; d = 8'h0C;
    nedge(2);
    chk("seedld_mode0", mode0, 1'b1);
    chk("seedld_s0", s0, 4'h7);
    nedge(1);
    n_lm = 1'b1;
    chk("seedld_s1", s1, 8'h0C);
    chk("seedld_s0b", s0, 4'hC);

    // Glitch between edges: never sampled
    #1 ch_s2 = 1'b0;
    #2 ch_s2 = 1'b1;
    nedge(1);
    chk("glitch_mode0", mode0, 1'b1);
    chk("glitch_mode1", mode1, 1'b1);

    // One-edge pulse: clean toggle, no earlier than the sync depth
    ch_s2 = 1'b0;
    nedge(1);
    ch_s2 = 1'b1;
    chk("pulse_e1_mode0", mode0, 1'b1);
    nedge(1);
    chk("pulse_e2_mode0", mode0, 1'b0);
    chk("pulse_e2_mode1", mode1, 1'b1);
    nedge(1);
    chk("pulse_e3_mode0", mode0, 1'b1);
    chk("pulse_e3_s0", s0, 4'h7);
    chk("pulse_e3_mode1", mode1, 1'b0);
    nedge(1);
    chk("pulse_e4_mode1", mode1, 1'b1);
    chk("pulse_e4_s1", s1, 8'h0C);

    // Manual-mode switches reach s without a clock
    ch_s2 = 1'b0;
    nedge(4);
    #2 a = 8'h3B;
    #1;
    chk("comb_s0", s0, 4'hB);
    chk("comb_s1", s1, 8'h3B);

    // Async reset mid-cycle in run mode
    ch_s2 = 1'b1;
    nedge(4);
    n_lm = 1'b0; d = 8'h40;
    nedge(1);
    n_lm = 1'b1;
    chk("r40_s1", s1, 8'h40);
    chk("r40_s0", s0, 4'h0);
    #2 n_rst = 1'b0;
    #1;
    chk("arst_s0", s0, 4'hB);
    chk("arst_s1", s1, 8'h3B);
    chk("arst_mode0", mode0, 1'b0);
    chk("arst_mode1", mode1, 1'b0);
    chk("arst_wrap0", wrap0, 1'b0);
    chk("arst_wrap1", wrap1, 1'b0);
    nedge(1);
    n_rst = 1'b1;
    nedge(1);
    chk("rel_e1_mode1", mode1, 1'b0);
    chk("rel_e1_s1", s1, 8'h3B);
    nedge(1);
    chk("rel_e2_s0", s0, 4'hB);
    nedge(1);
    chk("rel_e3_mode1", mode1, 1'b1);
    chk("rel_e3_s1", s1, 8'h10);
    nedge(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
